// File: rtl/fpu_arb_pkg.sv
// Shared encodings, defaults and the response-tag entry used by the FP-unit share arbiter.
package fpu_arb_pkg;

    localparam int unsigned NUM_REQ_DEF = 4;
    localparam int unsigned FU_LAT_DEF  = 8;
    localparam int unsigned ID_W        = 3;
    localparam int unsigned DATA_W      = 32;
    localparam int unsigned CNT_W       = 16;

    typedef enum logic {
        OP_MUL = 1'b0,
        OP_ADD = 1'b1
    } fu_op_e;

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
    } tag_t;

endpackage

// File: rtl/fpu_share_arbiter_rr.sv
// Combinational round-robin pick: lowest active request at or after ptr, wrapping.
module rr_arbiter
    import fpu_arb_pkg::*;
#(
    parameter int unsigned N = NUM_REQ_DEF
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic [N-1:0]    grant,
    output logic [ID_W-1:0] grant_idx
);

    logic [N-1:0] rot;
    logic         found;
    logic [3:0]   sum;

    // Rotate so that bit 0 is the requester at ptr.
    assign rot = N'({req, req} >> ptr);

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        sum       = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (!found && rot[k]) begin
                found = 1'b1;
                sum   = 4'(ptr) + 4'(k);
                if (sum >= 4'(N)) begin
                    sum = sum - 4'(N);
                end
                grant_idx = ID_W'(sum);
            end
        end
        if (found) begin
            grant = N'(1) << grant_idx;
        end
    end

endmodule

// File: rtl/fpu_share_arbiter.sv
// Shares one pipelined FP unit among NUM_REQ requesters with round-robin issue and tagged responses.
// Define FPU_ARB_STATS_EN to build the per-requester 16-bit grant counters.
module fpu_share_arbiter
    import fpu_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = NUM_REQ_DEF,
    parameter int unsigned FU_LAT  = FU_LAT_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ-1:0]       req_op,
    input  logic [NUM_REQ*32-1:0]    req_a,
    input  logic [NUM_REQ*32-1:0]    req_b,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     fu_issue,
    output logic                     fu_op,
    output logic [31:0]              fu_a,
    output logic [31:0]              fu_b,
    input  logic [31:0]              fu_result,
    output logic [NUM_REQ-1:0]       rsp_valid,
    output logic [31:0]              rsp_data,
    output logic [NUM_REQ*16-1:0]    grant_cnt
);

    logic [NUM_REQ-1:0] arb_req;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_idx;
    logic [ID_W-1:0]    ptr;
    logic [ID_W-1:0]    ptr_nxt;
    logic [3:0]         ptr_inc;
    logic               accept;
    logic               sel_op;
    logic [31:0]        sel_a;
    logic [31:0]        sel_b;
    tag_t               tags [FU_LAT+1];
    tag_t               tag_out;

    // Requests are masked during reset so nothing is granted or counted.
    assign arb_req   = rst ? '0 : req_valid;
    assign req_ready = grant;
    assign accept    = |grant;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .req       (arb_req),
        .ptr       (ptr),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    always_comb begin
        sel_op = 1'b0;
        sel_a  = '0;
        sel_b  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_op = req_op[i];
                sel_a  = req_a[i*32 +: 32];
                sel_b  = req_b[i*32 +: 32];
            end
        end
    end

    always_comb begin
        ptr_inc = 4'(grant_idx) + 4'd1;
        ptr_nxt = ptr;
        if (accept) begin
            ptr_nxt = (ptr_inc == 4'(NUM_REQ)) ? '0 : ID_W'(ptr_inc);
        end
    end

    // Issue registers and the tag pipe that lines requester ids up with fu_result.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr      <= '0;
            fu_issue <= 1'b0;
            fu_op    <= 1'b0;
            fu_a     <= '0;
            fu_b     <= '0;
            for (int unsigned k = 0; k <= FU_LAT; k++) begin
                tags[k] <= '0;
            end
        end else begin
            ptr      <= ptr_nxt;
            fu_issue <= accept;
            if (accept) begin
                fu_op <= sel_op;
                fu_a  <= sel_a;
                fu_b  <= sel_b;
            end
            tags[0] <= '{valid: accept, id: grant_idx};
            for (int unsigned k = 1; k <= FU_LAT; k++) begin
                tags[k] <= tags[k-1];
            end
        end
    end

    assign tag_out   = tags[FU_LAT];
    assign rsp_valid = tag_out.valid ? (NUM_REQ'(1) << tag_out.id) : '0;
    assign rsp_data  = fu_result;

`ifdef FPU_ARB_STATS_EN
    logic [CNT_W-1:0] cnt [NUM_REQ];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (grant[i]) begin
                    cnt[i] <= cnt[i] + 16'd1;
                end
            end
        end
    end

    always_comb begin
        grant_cnt = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            grant_cnt[i*CNT_W +: CNT_W] = cnt[i];
        end
    end
`else
    assign grant_cnt = '0;
`endif

endmodule

// File: tb/tb_fpu_share_arbiter.sv
// Randomized self-checking bench for fpu_share_arbiter with a queue-based reference model.
module tb_fpu_share_arbiter;

    localparam int N = 4;
    localparam int L = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_op = '0;
    logic [N*32-1:0] req_a = '0;
    logic [N*32-1:0] req_b = '0;
    logic [N-1:0]    req_ready;
    logic            fu_issue;
    logic            fu_op;
    logic [31:0]     fu_a;
    logic [31:0]     fu_b;
    logic [31:0]     fu_result;
    logic [N-1:0]    rsp_valid;
    logic [31:0]     rsp_data;
    logic [N*16-1:0] grant_cnt;

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    fpu_share_arbiter #(.NUM_REQ(N), .FU_LAT(L)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .fu_issue  (fu_issue),
        .fu_op     (fu_op),
        .fu_a      (fu_a),
        .fu_b      (fu_b),
        .fu_result (fu_result),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .grant_cnt (grant_cnt)
    );

    always #5 clk = ~clk;

    function automatic real sp2real(logic [31:0] x);
        logic [10:0] e;
        if (x[30:23] == 8'd0) return 0.0;
        e = 11'(x[30:23]) + 11'd896;
        return $bitstoreal({x[31], e, x[22:0], 29'd0});
    endfunction

    function automatic logic [31:0] real2sp(real r);
        logic [63:0] d;
        int e;
        d = $realtobits(r);
        if (d[62:52] == 11'd0) return {d[63], 31'd0};
        e = int'(d[62:52]) - 896;
        if (e <= 0) return {d[63], 31'd0};
        if (e >= 255) return {d[63], 8'hFF, 23'd0};
        return {d[63], 8'(e), d[51:29]};
    endfunction

    // Behavioural FP unit: op 1 adds, op 0 multiplies.
    function automatic logic [31:0] fp_calc(logic op, logic [31:0] a, logic [31:0] b);
        real ra, rb;
        ra = sp2real(a);
        rb = sp2real(b);
        return op ? real2sp(ra + rb) : real2sp(ra * rb);
    endfunction

    function automatic logic [31:0] rand_fp();
        return {1'($urandom_range(0, 1)), 8'($urandom_range(110, 140)), 23'($urandom)};
    endfunction

    // Shared FP unit stand-in: result appears L cycles after the issue cycle.
    logic [31:0] fu_pipe [L];
    always @(posedge clk) begin
        fu_pipe[0] <= fu_issue ? fp_calc(fu_op, fu_a, fu_b) : 32'h7FC0_0000;
        for (int k = 1; k < L; k++) fu_pipe[k] <= fu_pipe[k-1];
    end
    assign fu_result = fu_pipe[L-1];

    // Reference model state.
    typedef struct {
        int          due;
        int          id;
        logic [31:0] data;
    } exp_t;

    exp_t        rq[$];
    int          cyc = 0;
    int          mptr = 0;
    logic [15:0] mcnt [N];
    bit          p_acc = 1'b0;
    logic        p_op;
    logic [31:0] p_a, p_b;

    always @(negedge clk) begin
        logic [N-1:0]    exp_rv;
        logic [31:0]     exp_rd;
        logic [N-1:0]    exp_g;
        logic [N*16-1:0] exp_cnt;
        int              gid;
        #2;
        cyc++;
        exp_rv = '0;
        exp_rd = '0;
        if (rq.size() > 0 && rq[0].due == cyc) begin
            exp_rv = N'(1 << rq[0].id);
            exp_rd = rq[0].data;
            void'(rq.pop_front());
        end
        exp_cnt = '0;
`ifdef FPU_ARB_STATS_EN
        for (int i = 0; i < N; i++) exp_cnt[i*16 +: 16] = mcnt[i];
`endif
        if (mon_en) begin
            checks++;
            if (fu_issue !== p_acc) begin
                errors++;
                $display("FAIL mon_fu_issue cyc=%0d: got %b expected %b", cyc, fu_issue, p_acc);
            end
            if (p_acc) begin
                checks++;
                if ({fu_op, fu_a, fu_b} !== {p_op, p_a, p_b}) begin
                    errors++;
                    $display("FAIL mon_fu_operands cyc=%0d: got %b %h %h expected %b %h %h",
                             cyc, fu_op, fu_a, fu_b, p_op, p_a, p_b);
                end
            end
            if (!rst) begin
                checks++;
                if (rsp_valid !== exp_rv) begin
                    errors++;
                    $display("FAIL mon_rsp_valid cyc=%0d: got %b expected %b", cyc, rsp_valid, exp_rv);
                end
                if (exp_rv != '0) begin
                    checks++;
                    if (rsp_data !== exp_rd) begin
                        errors++;
                        $display("FAIL mon_rsp_data cyc=%0d: got %h expected %h", cyc, rsp_data, exp_rd);
                    end
                end
            end
            checks++;
            if (grant_cnt !== exp_cnt) begin
                errors++;
                $display("FAIL mon_grant_cnt cyc=%0d: got %h expected %h", cyc, grant_cnt, exp_cnt);
            end
        end
        gid = -1;
        if (!rst) begin
            for (int k = 0; k < N; k++) begin
                int j;
                j = (mptr + k) % N;
                if (gid < 0 && req_valid[j]) gid = j;
            end
        end
        exp_g = (gid >= 0) ? N'(1 << gid) : '0;
        if (mon_en) begin
            checks++;
            if (req_ready !== exp_g) begin
                errors++;
                $display("FAIL mon_req_ready cyc=%0d: got %b expected %b", cyc, req_ready, exp_g);
            end
        end
        p_acc = (gid >= 0);
        if (p_acc) begin
            p_op = req_op[gid];
            p_a  = 32'(req_a >> (32 * gid));
            p_b  = 32'(req_b >> (32 * gid));
            rq.push_back('{due: cyc + L + 1, id: gid, data: fp_calc(p_op, p_a, p_b)});
            mptr = (gid + 1) % N;
            mcnt[gid] = mcnt[gid] + 16'd1;
        end
        if (rst) begin
            mptr = 0;
            rq.delete();
            for (int i = 0; i < N; i++) mcnt[i] = '0;
        end
    end

    task automatic randomize_lanes();
        for (int i = 0; i < N; i++) begin
            req_a[i*32 +: 32] = rand_fp();
            req_b[i*32 +: 32] = rand_fp();
        end
        req_op = N'($urandom);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req_valid = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = '1;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (req_ready !== '0) begin errors++; $display("FAIL reset_req_ready: got %b expected 0", req_ready); end
        checks++;
        if ({fu_issue, fu_op} !== 2'b00) begin errors++; $display("FAIL reset_fu_ctl: got %b%b expected 00", fu_issue, fu_op); end
        checks++;
        if ({fu_a, fu_b} !== 64'd0) begin errors++; $display("FAIL reset_fu_operands: got %h %h expected 0", fu_a, fu_b); end
        checks++;
        if (rsp_valid !== '0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
        checks++;
        if (grant_cnt !== '0) begin errors++; $display("FAIL reset_grant_cnt: got %h expected 0", grant_cnt); end
        @(negedge clk);
        req_valid = '0;
        rst = 1'b0;
        mon_en = 1'b1;
    endtask

    task automatic test_single_add();
        @(negedge clk);
        randomize_lanes();
        req_valid = 4'b0100;
        req_op[2] = 1'b1;
        req_a[95:64] = 32'h3F80_0000;
        req_b[95:64] = 32'h4000_0000;
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_ready: got %b expected 0100", req_ready); end
        @(negedge clk);
        req_valid = '0;
        randomize_lanes();
        #1;
        checks++;
        if ({fu_issue, fu_op, fu_a, fu_b} !== {1'b1, 1'b1, 32'h3F80_0000, 32'h4000_0000}) begin
            errors++;
            $display("FAIL single_issue: got %b %b %h %h expected 1 1 3f800000 40000000", fu_issue, fu_op, fu_a, fu_b);
        end
        repeat (7) @(negedge clk);
        #1;
        checks++;
        if (rsp_valid !== '0) begin errors++; $display("FAIL single_early_rsp: got %b expected 0", rsp_valid); end
        @(negedge clk);
        #1;
        checks++;
        if (rsp_valid !== 4'b0100 || rsp_data !== 32'h4040_0000) begin
            errors++;
            $display("FAIL single_rsp: got %b %h expected 0100 40400000", rsp_valid, rsp_data);
        end
    endtask

    task automatic test_round_robin();
        int got[$];
        do_reset();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            randomize_lanes();
            req_valid = '1;
            #1;
            checks++;
            if (req_ready !== N'(1 << (i % N))) begin
                errors++;
                $display("FAIL rr_grant_%0d: got %b expected %b", i, req_ready, N'(1 << (i % N)));
            end
        end
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            req_valid = '0;
            #1;
            for (int i = 0; i < N; i++) if (rsp_valid[i]) got.push_back(i);
        end
        checks++;
        if (got.size() != 8) begin errors++; $display("FAIL rr_rsp_count: got %0d expected 8", got.size()); end
        for (int k = 0; k < got.size() && k < 8; k++) begin
            checks++;
            if (got[k] != k % N) begin errors++; $display("FAIL rr_rsp_order_%0d: got %0d expected %0d", k, got[k], k % N); end
        end
    endtask

    task automatic test_back_to_back();
        int n_acc = 0, n_iss = 0, n_rsp = 0, first = -1, last = -1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            randomize_lanes();
            req_valid = (c < 20) ? 4'b0010 : 4'b0000;
            #1;
            if (req_ready == 4'b0010) n_acc++;
            if (fu_issue) n_iss++;
            if (rsp_valid == 4'b0010) begin
                n_rsp++;
                if (first < 0) first = c;
                last = c;
            end
        end
        checks++;
        if (n_acc != 20 || n_iss != 20) begin errors++; $display("FAIL b2b_issue: got acc=%0d iss=%0d expected 20", n_acc, n_iss); end
        checks++;
        if (n_rsp != 20 || last - first != 19) begin
            errors++;
            $display("FAIL b2b_rsp: got %0d pulses span %0d expected 20 span 19", n_rsp, last - first);
        end
    endtask

    task automatic test_reset_inflight();
        int spur = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            randomize_lanes();
            req_valid = (c < 5) ? 4'b0010 : 4'b0000;
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (grant_cnt !== '0) begin errors++; $display("FAIL rstflight_cnt: got %h expected 0", grant_cnt); end
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            #1;
            if (rsp_valid != '0) spur++;
        end
        checks++;
        if (spur != 0) begin errors++; $display("FAIL rstflight_spurious: got %0d pulses expected 0", spur); end
        @(negedge clk);
        req_valid = '1;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin errors++; $display("FAIL rstflight_ptr: got %b expected 0001", req_ready); end
        @(negedge clk);
        req_valid = '0;
    endtask

    task automatic test_ptr_wrap();
        do_reset();
        @(negedge clk);
        req_valid = 4'b0100;
        @(negedge clk);
        req_valid = 4'b1001;
        #1;
        checks++;
        if (req_ready !== 4'b1000) begin errors++; $display("FAIL wrap_first: got %b expected 1000", req_ready); end
        @(negedge clk);
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin errors++; $display("FAIL wrap_second: got %b expected 0001", req_ready); end
        @(negedge clk);
        req_valid = '0;
    endtask

    task automatic test_random();
        logic [N-1:0] pend = '0;
        int wait_c [N];
        int max_wait = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            randomize_lanes();
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 2) != 0) begin
                    pend[i] = 1'b1;
                    wait_c[i] = 0;
                end
            end
            req_valid = pend;
            #1;
            for (int i = 0; i < N; i++) begin
                if (pend[i]) begin
                    if (req_ready[i]) begin
                        pend[i] = 1'b0;
                        if (wait_c[i] > max_wait) max_wait = wait_c[i];
                    end else begin
                        wait_c[i]++;
                    end
                end
            end
        end
        checks++;
        if (max_wait >= N) begin errors++; $display("FAIL random_starvation: got wait %0d expected < %0d", max_wait, N); end
        @(negedge clk);
        req_valid = '0;
        repeat (L + 3) @(negedge clk);
    endtask

    task automatic test_stats();
        int n;
        do_reset();
`ifdef FPU_ARB_STATS_EN
        n = 65537;
`else
        n = 20;
`endif
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            req_valid = 4'b0001;
        end
        @(negedge clk);
        req_valid = '0;
        #1;
        checks++;
`ifdef FPU_ARB_STATS_EN
        if (grant_cnt !== 64'h0000_0000_0000_0001) begin
            errors++;
            $display("FAIL stats_wrap: got %h expected 0000000000000001", grant_cnt);
        end
`else
        if (grant_cnt !== '0) begin
            errors++;
            $display("FAIL stats_disabled: got %h expected 0", grant_cnt);
        end
`endif
        repeat (L + 3) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_add();
        repeat (3) @(negedge clk);
        test_round_robin();
        test_back_to_back();
        test_reset_inflight();
        test_ptr_wrap();
        test_random();
        test_stats();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
